// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings: phase bus, fetch FSM states, default widths
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        PH_FETCH   = 2'b00,
        PH_DECODE  = 2'b01,
        PH_EXECUTE = 2'b10,
        PH_MEMORY  = 2'b11
    } phase_e;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_REQ  = 2'b01,
        FS_DONE = 2'b10,
        FS_ERR  = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetches one instruction word per FETCH phase over a req/ack memory handshake
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [1:0]        phase_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              pc_load_i,
    input  logic [ADDR_W-1:0] pc_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] ir_o,
    output logic              ir_valid_o,
    output logic              fetch_err_o
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

    fetch_state_e      state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;

    logic is_fetch;
    assign is_fetch = (phase_i == PH_FETCH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FS_IDLE;
            timer_q    <= '0;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (en_i) begin
            unique case (state_q)
                FS_IDLE: begin
                    if (is_fetch) begin
                        state_d    = FS_REQ;
                        timer_d    = '0;
                        ir_valid_d = 1'b0;
                    end
                end
                FS_REQ: begin
                    if (mem_ack_i) begin
                        ir_d       = mem_rdata_i;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_q + ADDR_W'(1);
                        state_d    = FS_DONE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                        if (timer_d == TIMER_MAX) begin
                            state_d = FS_ERR;
                        end
                    end
                end
                FS_DONE: begin
                    if (!is_fetch) begin
                        state_d = FS_IDLE;
                    end
                end
                default: begin
                end
            endcase
            // A taken branch overrides the post-fetch increment; the IR capture above still stands.
            if (pc_load_i && (phase_i == PH_EXECUTE)) begin
                pc_d       = pc_target_i;
                ir_valid_d = 1'b0;
            end
        end
    end

    // Handshake outputs decode the state register so reset drops mem_req without waiting for a clock.
    assign mem_req_o   = (state_q == FS_REQ);
    assign mem_addr_o  = pc_q;
    assign fetch_err_o = (state_q == FS_ERR);
    assign stall_o     = is_fetch && (state_q != FS_DONE);
    assign pc_o        = pc_q;
    assign ir_o        = ir_q;
    assign ir_valid_o  = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench with capture scoreboard for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic [1:0]  phase_i;
    logic        stall_o;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_ack_i;
    logic [15:0] mem_rdata_i;
    logic        pc_load_i;
    logic [15:0] pc_target_i;
    logic [15:0] pc_o;
    logic [15:0] ir_o;
    logic        ir_valid_o;
    logic        fetch_err_o;

    instr_fetch_unit dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .phase_i     (phase_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .pc_load_i   (pc_load_i),
        .pc_target_i (pc_target_i),
        .pc_o        (pc_o),
        .ir_o        (ir_o),
        .ir_valid_o  (ir_valid_o),
        .fetch_err_o (fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [1:0] FETCH = 2'b00, DECODE = 2'b01, EXECUTE = 2'b10, MEMORY = 2'b11;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_captures = 0;
    int   stall_cycles;
    logic iv_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [15:0] ir, input logic [15:0] pc);
        exp_t e;
        e.ir = ir;
        e.pc = pc;
        sb.push_back(e);
    endtask

    // Each rising edge of ir_valid marks one capture; it must match the oldest expected word.
    always @(negedge clk_i) begin
        if (rst_ni && ir_valid_o && !iv_prev) begin
            n_captures++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_capture", 32'(ir_o), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ir", 32'(ir_o), 32'(e.ir));
                chk("sb_pc", 32'(pc_o), 32'(e.pc));
            end
        end
        iv_prev <= ir_valid_o;
    end

    initial begin
        rst_ni = 1'b0; en_i = 1'b1; phase_i = DECODE;
        mem_ack_i = 1'b0; mem_rdata_i = '0; pc_load_i = 1'b0; pc_target_i = '0;
        tick();
        chk("rst_mem_req",   32'(mem_req_o), 32'h0);
        chk("rst_pc",        32'(pc_o), 32'h0);
        chk("rst_ir",        32'(ir_o), 32'h0);
        chk("rst_ir_valid",  32'(ir_valid_o), 32'h0);
        chk("rst_fetch_err", 32'(fetch_err_o), 32'h0);
        chk("rst_mem_addr",  32'(mem_addr_o), 32'h0);
        rst_ni = 1'b1;
        tick();

        // 1: ack on first REQ cycle
        phase_i = FETCH; #1;
        chk("t1_stall_idle", 32'(stall_o), 32'h1);
        chk("t1_req_idle",   32'(mem_req_o), 32'h0);
        tick();
        chk("t1_req",  32'(mem_req_o), 32'h1);
        chk("t1_addr", 32'(mem_addr_o), 32'h0);
        mem_ack_i = 1'b1; mem_rdata_i = 16'h1234; push(16'h1234, 16'h0001);
        tick();
        mem_ack_i = 1'b0;
        chk("t1_stall_low", 32'(stall_o), 32'h0);
        chk("t1_ir",        32'(ir_o), 32'h1234);
        chk("t1_ir_valid",  32'(ir_valid_o), 32'h1);
        chk("t1_pc",        32'(pc_o), 32'h0001);
        chk("t1_req_fall",  32'(mem_req_o), 32'h0);
        tick(); tick();
        chk("t1_no_refetch_req",   32'(mem_req_o), 32'h0);
        chk("t1_no_refetch_stall", 32'(stall_o), 32'h0);
        phase_i = DECODE;
        tick();
        chk("t1_iv_decode", 32'(ir_valid_o), 32'h1);

        // 2: ack arrives on the fifth REQ cycle
        stall_cycles = 0;
        phase_i = FETCH; #1;
        if (stall_o) stall_cycles++;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_req_held", 32'(mem_req_o), 32'h1);
            chk("t2_addr",     32'(mem_addr_o), 32'h0001);
            chk("t2_iv_low",   32'(ir_valid_o), 32'h0);
            if (stall_o) stall_cycles++;
            tick();
        end
        mem_ack_i = 1'b1; mem_rdata_i = 16'hABCD; push(16'hABCD, 16'h0002);
        chk("t2_req_ack", 32'(mem_req_o), 32'h1);
        if (stall_o) stall_cycles++;
        tick();
        mem_ack_i = 1'b0;
        if (stall_o) stall_cycles++;
        chk("t2_stall_cycles", 32'(stall_cycles), 32'd6);
        chk("t2_ir",           32'(ir_o), 32'hABCD);
        chk("t2_pc",           32'(pc_o), 32'h0002);
        tick();
        chk("t2_single_capture", 32'(n_captures), 32'd2);
        phase_i = DECODE;
        tick();

        // 3: branch ignored in DECODE, taken in EXECUTE
        pc_load_i = 1'b1; pc_target_i = 16'h0040;
        tick();
        chk("t3_decode_load_ignored", 32'(pc_o), 32'h0002);
        phase_i = EXECUTE;
        tick();
        pc_load_i = 1'b0;
        chk("t3_pc_loaded", 32'(pc_o), 32'h0040);
        chk("t3_iv_clear",  32'(ir_valid_o), 32'h0);
        phase_i = FETCH;
        tick();
        chk("t3_addr",   32'(mem_addr_o), 32'h0040);
        chk("t3_iv_req", 32'(ir_valid_o), 32'h0);
        mem_ack_i = 1'b1; mem_rdata_i = 16'h5555; push(16'h5555, 16'h0041);
        tick();
        mem_ack_i = 1'b0;
        chk("t3_iv_ack", 32'(ir_valid_o), 32'h1);
        phase_i = DECODE;
        tick();

        // 4: pc wraps at the top of the address space
        phase_i = EXECUTE; pc_load_i = 1'b1; pc_target_i = 16'hFFFF;
        tick();
        pc_load_i = 1'b0;
        chk("t4_pc_top", 32'(pc_o), 32'hFFFF);
        phase_i = FETCH;
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 16'hBEEF; push(16'hBEEF, 16'h0000);
        tick();
        mem_ack_i = 1'b0;
        chk("t4_pc_wrap", 32'(pc_o), 32'h0000);
        phase_i = MEMORY;
        tick();
        chk("t4_memory_stall", 32'(stall_o), 32'h0);

        // 6b then 5: en=0 freezes REQ, then timeout to ERR
        phase_i = FETCH;
        tick();
        en_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t6_en0_req_held", 32'(mem_req_o), 32'h1);
        chk("t6_en0_no_err",   32'(fetch_err_o), 32'h0);
        en_i = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("t5_req_before_timeout", 32'(mem_req_o), 32'h1);
        chk("t5_no_err_yet",         32'(fetch_err_o), 32'h0);
        tick();
        chk("t5_fetch_err", 32'(fetch_err_o), 32'h1);
        chk("t5_req_low",   32'(mem_req_o), 32'h0);
        chk("t5_stall",     32'(stall_o), 32'h1);
        phase_i = DECODE;
        tick();
        phase_i = FETCH; mem_ack_i = 1'b1; mem_rdata_i = 16'hDEAD;
        tick();
        mem_ack_i = 1'b0;
        chk("t5_err_sticky",  32'(fetch_err_o), 32'h1);
        chk("t5_err_stall",   32'(stall_o), 32'h1);
        chk("t5_ack_ignored", 32'(ir_o), 32'hBEEF);
        rst_ni = 1'b0; #1;
        chk("t5_reset_clears", 32'(fetch_err_o), 32'h0);
        tick();
        rst_ni = 1'b1; phase_i = DECODE;
        tick();

        // 6: reset asserted mid-REQ
        phase_i = FETCH;
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 16'h1111; push(16'h1111, 16'h0001);
        tick();
        mem_ack_i = 1'b0; phase_i = DECODE;
        tick();
        phase_i = FETCH;
        tick();
        chk("t6_req_mid",  32'(mem_req_o), 32'h1);
        chk("t6_addr_mid", 32'(mem_addr_o), 32'h0001);
        #2 rst_ni = 1'b0; #1;
        chk("t6_req_async", 32'(mem_req_o), 32'h0);
        chk("t6_pc_reset",  32'(pc_o), 32'h0000);
        chk("t6_iv_reset",  32'(ir_valid_o), 32'h0);
        tick();
        chk("t_sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
